// File: rtl/cdr_serial_tx.sv
// cdr_serial_tx - transmit end of the CDR link.
//
// Serialises WIDTH-bit words MSB-first at one bit per clk. After reset, and
// whenever a retrain is requested, it sends a 1010... training preamble and
// then SYNC_WORD. Once the link is up, back-to-back WIDTH-bit slots each carry
// either an accepted word or IDLE_WORD. A PRBS7 (x^7+x^6+1) test mode is also
// available.
//
// Ports:
//   clk      bit clock, rising edge
//   rst      asynchronous reset, active low
//   data_in  word to send, held stable while valid=1
//   valid    data_in available
//   ready    combinational; the word is taken on the edge where valid&ready
//   train    retrain request, sampled at slot boundaries
//   prbs_en  PRBS7 test mode request, sampled at slot boundaries
//   dout     registered serial data
//   link_up  registered, high while slots are being sent
module cdr_serial_tx #(
    parameter int               WIDTH        = 8,
    parameter int               PREAMBLE_LEN = 16,
    parameter logic [WIDTH-1:0] SYNC_WORD    = 8'hD5,
    parameter logic [WIDTH-1:0] IDLE_WORD    = 8'hAA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    input  logic             train,
    input  logic             prbs_en,
    output logic             dout,
    output logic             link_up
);

    localparam int         CNT_MAX   = (PREAMBLE_LEN > WIDTH) ? PREAMBLE_LEN : WIDTH;
    localparam int         CW        = $clog2(CNT_MAX + 1);
    localparam logic [6:0] LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {ST_TRAIN, ST_SYNC, ST_LINK, ST_PRBS} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    bitcnt, bitcnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [6:0]       lfsr, lfsr_n;
    logic             dout_n;
    logic             link_up_n;
    logic             slot_end;
    logic [WIDTH-1:0] slot_word;

    function automatic logic [6:0] lfsr_step(input logic [6:0] l);
        return {l[5:0], l[6] ^ l[5]};
    endfunction

    // In SYNC/LINK, bitcnt is the index of the bit currently on dout, so the
    // boundary edge (bitcnt==WIDTH-1) already drives the first bit of the next
    // slot. That lets an accepted word appear on dout at the acceptance edge.
    // In TRAIN, bitcnt counts preamble bits already sent (0..PREAMBLE_LEN).
    assign slot_end  = (bitcnt == CW'(WIDTH - 1));
    assign ready     = ((state == ST_SYNC) || (state == ST_LINK)) && slot_end
                       && !train && !prbs_en;
    assign slot_word = (ready && valid) ? data_in : IDLE_WORD;

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        lfsr_n   = lfsr;
        dout_n   = dout;
        case (state)
            ST_TRAIN: begin
                if (bitcnt == CW'(PREAMBLE_LEN)) begin
                    state_n  = ST_SYNC;
                    bitcnt_n = '0;
                    dout_n   = SYNC_WORD[WIDTH-1];
                    shreg_n  = {SYNC_WORD[WIDTH-2:0], 1'b0};
                end else begin
                    dout_n   = ~bitcnt[0];
                    bitcnt_n = bitcnt + CW'(1);
                end
            end
            ST_SYNC, ST_LINK: begin
                if (!slot_end) begin
                    dout_n   = shreg[WIDTH-1];
                    shreg_n  = {shreg[WIDTH-2:0], 1'b0};
                    bitcnt_n = bitcnt + CW'(1);
                end else if (train) begin
                    // first preamble bit goes out on this edge
                    state_n  = ST_TRAIN;
                    bitcnt_n = CW'(1);
                    dout_n   = 1'b1;
                end else if (prbs_en) begin
                    // first PRBS bit goes out on this edge, seeded from 7'h7F
                    state_n  = ST_PRBS;
                    bitcnt_n = '0;
                    dout_n   = LFSR_SEED[6];
                    lfsr_n   = lfsr_step(LFSR_SEED);
                end else begin
                    state_n  = ST_LINK;
                    bitcnt_n = '0;
                    dout_n   = slot_word[WIDTH-1];
                    shreg_n  = {slot_word[WIDTH-2:0], 1'b0};
                end
            end
            ST_PRBS: begin
                if (!prbs_en) begin
                    state_n  = ST_TRAIN;
                    bitcnt_n = CW'(1);
                    dout_n   = 1'b1;
                end else begin
                    dout_n = lfsr[6];
                    lfsr_n = lfsr_step(lfsr);
                end
            end
            default: begin
                state_n  = ST_TRAIN;
                bitcnt_n = '0;
            end
        endcase
        link_up_n = (state_n == ST_LINK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_TRAIN;
            bitcnt  <= '0;
            shreg   <= '0;
            lfsr    <= LFSR_SEED;
            dout    <= 1'b0;
            link_up <= 1'b0;
        end else begin
            state   <= state_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            lfsr    <= lfsr_n;
            dout    <= dout_n;
            link_up <= link_up_n;
        end
    end

endmodule

// File: doc/cdr_serial_tx.md
Name: cdr_serial_tx

Overview:
- Serial transmitter that generates the bitstream our CDR receiver recovers. It is the transmit end of the link.
- It takes parallel words through a valid/ready handshake and serialises them MSB-first at one bit per clock.
- Before data, it sends a transition-rich training preamble and a sync word so the receiver's bang-bang phase detector and loop can lock.
- It has a PRBS7 test mode for loop characterisation.

Parameters:
- WIDTH, 8, word width in bits; even, at least 4.
- PREAMBLE_LEN, 16, number of training bits; pattern is 1,0,1,0,...
- SYNC_WORD, 8'hD5, word sent once after the preamble; WIDTH bits.
- IDLE_WORD, 8'hAA, fill word sent in any link slot with no accepted data.

Ports:
- clk  input  1  bit clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to transmit; must be stable while valid=1.
- valid  input  1  data_in is available.
- ready  output  1  word accepted at the rising edge where valid&ready=1.
- train  input  1  retrain request; level-sampled at slot boundaries.
- prbs_en  input  1  PRBS7 test mode request; level-sampled at slot boundaries.
- dout  output  1  serial data, registered.
- link_up  output  1  high while in the LINK state, registered.

Behaviour:
- Reset (rst=0, asynchronous): dout=0, link_up=0, state=TRAIN, bitcnt=0, LFSR=7'h7F. ready=0 during reset.
- Reset mid-operation aborts the current word immediately. Any word in flight is lost.
- State machine states: TRAIN, SYNC, LINK, PRBS. bitcnt counts the bits in the current slot/phase.
- TRAIN: sends PREAMBLE_LEN bits. Bit i is 1 when i is even, 0 when odd. After the last bit, go to SYNC.
- SYNC: sends SYNC_WORD MSB-first over WIDTH cycles, then goes to LINK.
- LINK: sends WIDTH-bit slots back-to-back with no gap between slots.
  - Each slot carries the accepted word, or IDLE_WORD if no word was accepted.
- Slot boundary: the cycle where bitcnt==WIDTH-1 in SYNC or LINK.
- ready is combinational: ready = (state==SYNC or LINK) and bitcnt==WIDTH-1 and train==0 and prbs_en==0.
- Handshake and latency: if valid&ready at edge k, dout=data_in[WIDTH-1] after edge k and dout=data_in[0] after edge k+WIDTH-1.
  - The full rate of one word per WIDTH cycles is reachable with valid held high.
- valid without ready: no acceptance. The word must be held by the source.
- Priority at a LINK slot boundary: train=1 goes to TRAIN; else prbs_en=1 goes to PRBS; else the next slot (data or idle).
  - The current slot always completes; training never truncates a word.
- train at the SYNC boundary restarts TRAIN.
- train or prbs_en asserted mid-slot has no effect until the boundary.
- link_up: 1 from the first LINK bit onward. It falls on the edge that leaves LINK.
- PRBS state:
  - Polynomial x^7+x^6+1; dout = lfsr[6]; each cycle lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - LFSR is reloaded to 7'h7F on PRBS entry.
  - ready=0 throughout.
  - On the first cycle with prbs_en=0, go to TRAIN (the receiver must relock).
- dout changes only on rising clk edges; it is never combinational.

Test Plan (WIDTH=8, PREAMBLE_LEN=16, SYNC_WORD=D5, IDLE_WORD=AA):
- Release reset with valid=0 -> edges 1-16 give dout 1010...10; edges 17-24 give 11010101; link_up=1 after edge 25; then 10101010 repeats. ready is high in cycle 24 and every 8th cycle after.
- valid held with words 3C then FF -> dout 00111100 then 11111111 contiguous. ready is 1 exactly once per accepted word. The next slot is AA if valid drops.
- valid=1 raised mid-slot -> word not accepted until the ready cycle. It appears starting at the next slot boundary, and the current slot is not disturbed.
- train pulsed for 1 cycle mid-slot -> no effect (sampled only at boundary); held through the boundary -> current word completes, link_up falls, then 16-bit preamble, D5, link_up rises. ready stays 0 throughout.
- prbs_en=1 in LINK -> after the boundary, dout 1111111 then 0. The sequence period is exactly 127 bits. Dropping prbs_en gives preamble then D5.
- rst low mid-word -> dout=0 and link_up=0 immediately, without a clock. After release the preamble restarts with 1 and the interrupted word is never emitted.
